easyaxi_rd_slv: RTL and testbench

- AXI read slave that sits directly downstream of the outstanding-capable read master.
- Accepts AR requests into an in-order outstanding queue and generates FIXED/INCR/WRAP burst addresses.
- Returns R beats from an internal word memory, with RID, RRESP and RLAST per beat.
- Serves as the bench target for master burst/outstanding tests and reports protocol errors through RRESP.

---
 rtl/easyaxi_rd_slv_pkg.sv | 58 +++++
 rtl/easyaxi_burst_addr_gen.sv | 33 +++
 rtl/easyaxi_rd_slv.sv | 166 ++++++++++++++++
 tb/tb_easyaxi_rd_slv.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared AXI widths/encodings and the types used by the easyaxi read slave.
`ifndef EASYAXI_DEFINE_SVH
`define EASYAXI_DEFINE_SVH
`define AXI_ID_W         4
`define AXI_ADDR_W       32
`define AXI_LEN_W        8
`define AXI_SIZE_W       3
`define AXI_BURST_W      2
`define AXI_DATA_W       32
`define AXI_RESP_W       2
`define AXI_BURST_FIXED  2'b00
`define AXI_BURST_INCR   2'b01
`define AXI_BURST_WRAP   2'b10
`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_EXOKAY  2'b01
`define AXI_RESP_SLVERR  2'b10
`define AXI_RESP_DECERR  2'b11
`endif

package easyaxi_rd_slv_pkg;

    localparam int unsigned AXI_ID_W    = `AXI_ID_W;
    localparam int unsigned AXI_ADDR_W  = `AXI_ADDR_W;
    localparam int unsigned AXI_LEN_W   = `AXI_LEN_W;
    localparam int unsigned AXI_SIZE_W  = `AXI_SIZE_W;
    localparam int unsigned AXI_BURST_W = `AXI_BURST_W;
    localparam int unsigned AXI_DATA_W  = `AXI_DATA_W;
    localparam int unsigned AXI_RESP_W  = `AXI_RESP_W;
    localparam int unsigned ADDR_LSB    = $clog2(AXI_DATA_W / 8);

    localparam logic [AXI_BURST_W-1:0] BURST_FIXED = `AXI_BURST_FIXED;
    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = `AXI_BURST_INCR;
    localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = `AXI_BURST_WRAP;
    localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = `AXI_RESP_OKAY;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = `AXI_RESP_EXOKAY;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = `AXI_RESP_SLVERR;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = `AXI_RESP_DECERR;

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_req_t;

    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/easyaxi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus WRAP length legality.
module easyaxi_burst_addr_gen
    import easyaxi_rd_slv_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0]  i_addr,
    input  logic [AXI_LEN_W-1:0]   i_len,
    input  logic [AXI_SIZE_W-1:0]  i_size,
    input  logic [AXI_BURST_W-1:0] i_burst,
    output logic [AXI_ADDR_W-1:0]  o_next_addr,
    output logic                   o_wrap_ok
);

    logic [AXI_ADDR_W-1:0] w_step;
    logic [AXI_ADDR_W-1:0] w_bound;
    logic [AXI_ADDR_W-1:0] w_mask;
    logic [AXI_ADDR_W-1:0] w_incr;

    always_comb begin
        w_step    = AXI_ADDR_W'(1) << i_size;
        w_bound   = (AXI_ADDR_W'(i_len) + AXI_ADDR_W'(1)) << i_size;
        w_mask    = w_bound - AXI_ADDR_W'(1);
        w_incr    = i_addr + w_step;
        o_wrap_ok = wrap_len_ok(i_len);
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            // Keep the aligned window base, let the offset roll over inside it.
            BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:     o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI read slave: in-order AR queue, burst sequencer and word memory returning R beats.
module easyaxi_rd_slv
    import easyaxi_rd_slv_pkg::*;
#(
    parameter int unsigned OST_DEPTH     = 4,
    parameter int unsigned MEM_DEPTH     = 64,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi_slv_arvalid,
    output logic                   axi_slv_arready,
    input  logic [AXI_ID_W-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
    output logic                   axi_slv_rvalid,
    input  logic                   axi_slv_rready,
    output logic [AXI_ID_W-1:0]    axi_slv_rid,
    output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
    output logic                   axi_slv_rlast,
    output logic                   busy
);

    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(MEM_DEPTH << ADDR_LSB);

    ar_req_t                r_queue [OST_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;
    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [AXI_ID_W-1:0]    r_id;
    logic [AXI_ADDR_W-1:0]  r_addr;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [AXI_SIZE_W-1:0]  r_size;
    logic [AXI_BURST_W-1:0] r_burst;
    logic [AXI_LEN_W-1:0]   r_beat_cnt;
    logic [AXI_DATA_W-1:0]  r_mem [MEM_DEPTH];

    ar_req_t               w_req;
    ar_req_t               w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_advance;
    logic                  w_rvalid;
    logic                  w_last;
    logic                  w_slverr;
    logic                  w_decerr;
    logic                  w_wrap_ok;
    logic [AXI_ADDR_W-1:0] w_next_addr;

    assign w_full          = (r_count == (PTR_W + 1)'(OST_DEPTH));
    assign w_empty         = (r_count == '0);
    assign axi_slv_arready = ~w_full & ~rst;
    assign w_push          = axi_slv_arvalid & axi_slv_arready;
    assign w_head          = r_queue[r_rd_ptr];
    assign w_req           = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                               size: axi_slv_arsize, burst: axi_slv_arburst};
    assign w_rvalid        = (r_state == StBurst);
    assign w_last          = (r_beat_cnt == r_len);
    assign busy            = ~w_empty | w_rvalid;

    easyaxi_burst_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_wrap_ok   (w_wrap_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StBurst;
                end
            end
            StBurst: begin
                if (axi_slv_rready) begin
                    // Reload straight from the queue so consecutive bursts have no bubble.
                    if (w_last) begin
                        if (!w_empty) w_pop = 1'b1;
                        else          w_state_nxt = StIdle;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            for (int k = 0; k < MEM_DEPTH; k++) r_mem[k] <= AXI_DATA_W'(k);
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_id       <= w_head.id;
                r_addr     <= w_head.addr;
                r_len      <= w_head.len;
                r_size     <= w_head.size;
                r_burst    <= w_head.burst;
                r_beat_cnt <= '0;
            end else if (w_advance) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_queue[r_wr_ptr] <= w_req;
    end

    // Burst fields are frozen for the whole burst, so this error holds for every beat.
    assign w_slverr = (r_burst == BURST_RSVD) || (32'(r_size) > ADDR_LSB) ||
                      ((r_burst == BURST_WRAP) && !w_wrap_ok) ||
                      (32'(r_len) >= MAX_BURST_LEN);
    assign w_decerr = (r_addr >= MEM_BYTES);

    always_comb begin
        axi_slv_rvalid = w_rvalid;
        axi_slv_rid    = '0;
        axi_slv_rdata  = '0;
        axi_slv_rresp  = RESP_OKAY;
        axi_slv_rlast  = 1'b0;
        if (w_rvalid) begin
            axi_slv_rid   = r_id;
            axi_slv_rlast = w_last;
            if (w_slverr)      axi_slv_rresp = RESP_SLVERR;
            else if (w_decerr) axi_slv_rresp = RESP_DECERR;
            else               axi_slv_rdata = r_mem[r_addr[ADDR_LSB +: IDX_W]];
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Self-checking bench for easyaxi_rd_slv against a queue-based burst model.
module tb_easyaxi_rd_slv;
    import easyaxi_rd_slv_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        busy;

    int    n_cmp  = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    bit    coll_done;

    always #5 clk = ~clk;

    easyaxi_rd_slv #(
        .OST_DEPTH     (4),
        .MEM_DEPTH     (64),
        .MAX_BURST_LEN (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arsize  (arsize),
        .axi_slv_arburst (arburst),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast),
        .busy            (busy)
    );

    function automatic ar_req_t mk_ar(int id, int addr, int len, int size, int burst);
        mk_ar = '{id: 4'(id), addr: 32'(addr), len: 8'(len), size: 3'(size), burst: 2'(burst)};
    endfunction

    // 64 words x 4 bytes, word k holds k; beats are derived from the burst rules directly.
    function automatic void model_push(input ar_req_t ar);
        longint unsigned a, step, bound, base;
        bit    slv;
        beat_t b;
        a     = ar.addr;
        step  = 64'd1 << ar.size;
        bound = (longint'(ar.len) + 1) * step;
        slv   = (ar.burst == 2'b11) || (ar.size > 2) || (ar.len >= 16) ||
                (ar.burst == 2'b10 && !(ar.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        for (int i = 0; i <= int'(ar.len); i++) begin
            b.id   = ar.id;
            b.last = (i == int'(ar.len));
            if (slv)           begin b.resp = 2'd2; b.data = 32'd0; end
            else if (a >= 256) begin b.resp = 2'd3; b.data = 32'd0; end
            else               begin b.resp = 2'd0; b.data = 32'(a / 4); end
            exp_q.push_back(b);
            if (ar.burst == 2'b01) a = (a + step) % (64'd1 << 32);
            else if (ar.burst == 2'b10 && !slv) begin
                base = a - (a % bound);
                a    = base + ((a - base + step) % bound);
            end
        end
    endfunction

    task automatic send_ar(input ar_req_t ar, input int bound);
        bit hs = 1'b0;
        arvalid = 1'b1;
        arid    = ar.id;
        araddr  = ar.addr;
        arlen   = ar.len;
        arsize  = ar.size;
        arburst = ar.burst;
        for (int c = 0; c < bound && !hs; c++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        n_cmp++;
        if (!hs) begin
            n_fail++;
            $display("FAIL ar_handshake id=%0d: got no accept, want accept within %0d cycles",
                     ar.id, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({arready, rvalid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_during: got arready/rvalid/busy=%b, want 000",
                     {arready, rvalid, busy});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({arready, rvalid, rlast, busy, rid, rdata, rresp} !== {4'b1000, 38'd0}) begin
            n_fail++;
            $display("FAIL reset_after: got arready=%b rvalid=%b rlast=%b busy=%b rid=%0h rdata=%0h rresp=%0d, want arready=1 all others 0",
                     arready, rvalid, rlast, busy, rid, rdata, rresp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        ar_req_t tbl[8];
        beat_t   exp, got;
        tbl[0] = mk_ar(1, 'h10, 3, 2, 1);
        tbl[1] = mk_ar(2, 'h34, 3, 2, 2);
        tbl[2] = mk_ar(3, 'h30, 2, 2, 2);
        tbl[3] = mk_ar(4, 'h30, 3, 2, 0);
        tbl[4] = mk_ar(5, 'hF8, 3, 2, 1);
        tbl[5] = mk_ar(6, 'h00, 1, 2, 3);
        tbl[6] = mk_ar(7, 'h00, 0, 3, 1);
        tbl[7] = mk_ar(8, 'h00, 16, 2, 1);
        rready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            model_push(tbl[t]);
            send_ar(tbl[t], 20);
            for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
                @(negedge clk);
                if (rvalid) begin
                    exp = exp_q.pop_front();
                    got = {rid, rdata, rresp, rlast};
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL directed_%0d: got id=%0h data=%0h resp=%0d last=%0b, want id=%0h data=%0h resp=%0d last=%0b",
                                 t, got.id, got.data, got.resp, got.last,
                                 exp.id, exp.data, exp.resp, exp.last);
                    end
                end
            end
            if (exp_q.size() > 0) begin
                n_cmp++; n_fail++;
                $display("FAIL directed_%0d_timeout: got %0d beats missing, want 0", t, exp_q.size());
                exp_q.delete();
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic collect(input string name, input bit check_bubble, input int bound);
        beat_t exp, got, prev;
        bit    prev_stall = 1'b0;
        bit    want_valid = 1'b0;
        int    guard = 0;
        prev = '0;
        while (exp_q.size() > 0 && guard < bound) begin
            @(negedge clk);
            guard++;
            got = {rid, rdata, rresp, rlast};
            if (prev_stall) begin
                n_cmp++;
                if (!rvalid || got !== prev) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: got rvalid=%b payload=%h, want rvalid=1 payload=%h",
                             name, rvalid, got, prev);
                end
            end
            if (want_valid) begin
                n_cmp++;
                if (rvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_no_bubble: got rvalid=%b after rlast, want 1", name, rvalid);
                end
            end
            want_valid = 1'b0;
            prev_stall = rvalid && !rready;
            prev       = got;
            if (rvalid && rready) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s_beat: got id=%0h data=%0h resp=%0d last=%0b, want id=%0h data=%0h resp=%0d last=%0b",
                             name, got.id, got.data, got.resp, got.last,
                             exp.id, exp.data, exp.resp, exp.last);
                end
                if (check_bubble && exp.last && exp_q.size() > 0) want_valid = 1'b1;
            end
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got %0d beats missing, want 0", name, exp_q.size());
            exp_q.delete();
        end
        coll_done = 1'b1;
    endtask

    task automatic test_outstanding();
        ar_req_t ars[6];
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ars[i] = mk_ar(i, i * 16, 1, 2, 1);
            model_push(ars[i]);
        end
        for (int i = 0; i < 5; i++) send_ar(ars[i], 10);
        arvalid = 1'b1; arid = ars[5].id; araddr = ars[5].addr;
        arlen = ars[5].len; arsize = ars[5].size; arburst = ars[5].burst;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (arready !== 1'b0) begin
                n_fail++;
                $display("FAIL outstanding_full: got arready=%b with 4 queued + 1 active, want 0", arready);
            end
        end
        @(posedge clk); #1;
        coll_done = 1'b0;
        fork
            send_ar(ars[5], 200);
            begin
                for (int c = 0; c < 4000 && !coll_done; c++) begin
                    rready = ((c / 2) % 2) == 0;
                    @(posedge clk); #1;
                end
            end
            collect("outstanding", 1'b1, 2000);
        join
        rready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midburst();
        beat_t   exp, got;
        ar_req_t ar;
        bit      seen = 1'b0;
        rready = 1'b1;
        ar = mk_ar(3, 'h00, 7, 2, 1);
        send_ar(ar, 20);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1'b1;
                n_cmp++;
                if ({rid, rdata, rlast} !== {4'd3, 32'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL midburst_beat1: got id=%0h data=%0h last=%b, want id=3 data=0 last=0",
                             rid, rdata, rlast);
                end
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rvalid, busy, arready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midburst_reset: got rvalid/busy/arready=%b, want 001", {rvalid, busy, arready});
        end
        @(posedge clk); #1;
        ar = mk_ar(9, 'h20, 3, 2, 1);
        model_push(ar);
        send_ar(ar, 20);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (rvalid) begin
                exp = exp_q.pop_front();
                got = {rid, rdata, rresp, rlast};
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL midburst_new: got id=%0h data=%0h resp=%0d last=%0b, want id=%0h data=%0h resp=%0d last=%0b",
                             got.id, got.data, got.resp, got.last, exp.id, exp.data, exp.resp, exp.last);
                end
            end
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL midburst_new_timeout: got %0d beats missing, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        ar_req_t ars[24];
        int      lens[8] = '{0, 1, 2, 3, 7, 15, 16, 5};
        for (int i = 0; i < 24; i++) begin
            ars[i] = mk_ar($urandom_range(0, 15), $urandom_range(0, 'h13F),
                           lens[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));
            model_push(ars[i]);
        end
        coll_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send_ar(ars[i], 400);
                end
            end
            begin
                for (int c = 0; c < 8000 && !coll_done; c++) begin
                    rready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            collect("random", 1'b0, 6000);
        join
        rready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_outstanding();
        test_reset_midburst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
